// File: rtl/seq_priority_encoder_32to5_pkg.sv
// Shared definitions for the sequential 32-to-5 priority encoder.
//   WIDTH  request vector width (32 only)
//   IDX_W  index width, log2(WIDTH)
//   CNT_W  remaining-count width, IDX_W+1
//   state_t  controller states
package seq_priority_encoder_32to5_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/seq_priority_encoder_32to5_if.sv
// Handshake bundle between the encoder and its consumer.
//   load/req        capture request (consumer -> encoder)
//   idx_ready       consumer accepts idx
//   busy/idx_valid  encoder status, idx/remaining/done results
// Modports: master = consumer side, slave = encoder side.
interface seq_priority_encoder_32to5_if;
  import seq_priority_encoder_32to5_pkg::*;

  logic             load;
  logic [WIDTH-1:0] req;
  logic             idx_ready;
  logic             busy;
  logic             idx_valid;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] remaining;
  logic             done;

  modport master (
    output load, req, idx_ready,
    input  busy, idx_valid, idx, remaining, done
  );

  modport slave (
    input  load, req, idx_ready,
    output busy, idx_valid, idx, remaining, done
  );

endinterface

// File: rtl/seq_priority_encoder_32to5_ffs.sv
// Combinational find-first-set encoder over a 32-bit vector.
//   vec  input vector
//   idx  index of the lowest set bit (don't-care when any=0)
//   any  OR of all bits of vec
// Four 8-bit priority encoders are merged into two 16-bit halves,
// then the halves are merged into the final 5-bit index.
module ffs_encoder32
  import seq_priority_encoder_32to5_pkg::*;
(
  output logic [IDX_W-1:0] idx,
  output logic             any,
  input  logic [WIDTH-1:0] vec
);

  // Returns {any, index} of the lowest set bit in an 8-bit slice.
  function automatic logic [3:0] pe8(input logic [7:0] v);
    logic [3:0] r;
    r = '0;
    // Scan from the top down so the lowest set bit is written last.
    for (int unsigned i = 8; i > 0; i--) begin
      if (v[i-1]) r = {1'b1, 3'(i - 1)};
    end
    return r;
  endfunction

  logic [3:0] w_byte [4];
  logic [4:0] w_half0;
  logic [4:0] w_half1;

  always_comb begin
    for (int unsigned b = 0; b < 4; b++) begin
      w_byte[b] = pe8(vec[8*b +: 8]);
    end
  end

  // {any, 4-bit index} for each 16-bit half, low byte has priority.
  assign w_half0 = w_byte[0][3] ? {1'b1, 1'b0, w_byte[0][2:0]}
                                : {w_byte[1][3], 1'b1, w_byte[1][2:0]};
  assign w_half1 = w_byte[2][3] ? {1'b1, 1'b0, w_byte[2][2:0]}
                                : {w_byte[3][3], 1'b1, w_byte[3][2:0]};

  assign idx = w_half0[4] ? {1'b0, w_half0[3:0]} : {1'b1, w_half1[3:0]};
  assign any = w_half0[4] | w_half1[4];

endmodule

// File: rtl/seq_priority_encoder_32to5.sv
// Sequential 32-to-5 encoder: captures a request vector and emits the
// index of each set bit, lowest first, one per accepted handshake.
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  slave side of seq_priority_encoder_32to5_if
//        (load/req in, idx_valid/idx/idx_ready handshake,
//         busy, remaining count, done pulse)
module seq_priority_encoder_32to5
  import seq_priority_encoder_32to5_pkg::*;
(
  input logic                        clk,
  input logic                        rst,
  seq_priority_encoder_32to5_if.slave bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_pending;
  logic [CNT_W-1:0] r_remaining;
  logic             r_done;

  logic [IDX_W-1:0] w_ffs_idx;
  logic             w_any;
  logic             w_valid;
  logic             w_accept;
  logic [CNT_W-1:0] w_req_pop;

  // Popcount adder tree on req; result is registered on load.
  logic [1:0] w_s1 [16];
  logic [2:0] w_s2 [8];
  logic [3:0] w_s3 [4];
  logic [4:0] w_s4 [2];

  always_comb begin
    for (int unsigned i = 0; i < 16; i++)
      w_s1[i] = {1'b0, bus.req[2*i]} + {1'b0, bus.req[2*i+1]};
    for (int unsigned i = 0; i < 8; i++)
      w_s2[i] = {1'b0, w_s1[2*i]} + {1'b0, w_s1[2*i+1]};
    for (int unsigned i = 0; i < 4; i++)
      w_s3[i] = {1'b0, w_s2[2*i]} + {1'b0, w_s2[2*i+1]};
    for (int unsigned i = 0; i < 2; i++)
      w_s4[i] = {1'b0, w_s3[2*i]} + {1'b0, w_s3[2*i+1]};
    w_req_pop = {1'b0, w_s4[0]} + {1'b0, w_s4[1]};
  end

  ffs_encoder32 u_ffs (
    .idx (w_ffs_idx),
    .any (w_any),
    .vec (r_pending)
  );

  assign w_valid  = (r_state == SCAN) && w_any;
  assign w_accept = w_valid && bus.idx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.load) begin
            r_pending   <= bus.req;
            r_remaining <= w_req_pop;
            // An all-zero vector is acknowledged with done and no scan.
            if (bus.req == '0) r_done  <= 1'b1;
            else               r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_accept) begin
            r_pending[w_ffs_idx] <= 1'b0;
            r_remaining          <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state == SCAN);
  assign bus.idx_valid = w_valid;
  assign bus.idx       = w_valid ? w_ffs_idx : '0;
  assign bus.remaining = r_remaining;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_seq_priority_encoder_32to5.sv
module tb_seq_priority_encoder_32to5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_priority_encoder_32to5_if bus ();

  seq_priority_encoder_32to5 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {busy, idx_valid, idx[4:0], remaining[5:0], done}
  logic [13:0] obs;
  assign obs = {bus.busy, bus.idx_valid, bus.idx, bus.remaining, bus.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    logic [13:0] exp_v;
    rst = 1'b0;
    bus.load = 1'b0;
    bus.req = '0;
    bus.idx_ready = 1'b0;
    #3;
    exp_v = '0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [13:0] exp_v;
    int exp_idx [3] = '{2, 9, 11};
    bus.load = 1'b1;
    bus.req = 32'h0000_0A04;
    bus.idx_ready = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_v = {1'b1, 1'b1, 5'(exp_idx[k]), 6'(3 - k), 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL basic_idx%0d: got %h expected %h", k, obs, exp_v);
      end
      @(negedge clk);
    end
    exp_v = {1'b0, 1'b0, 5'd0, 6'd0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL basic_done: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = '0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL basic_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_stall();
    logic [13:0] exp_v;
    bus.load = 1'b1;
    bus.req = 32'h8000_0001;
    bus.idx_ready = 1'b0;
    @(negedge clk);
    bus.load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_v = {1'b1, 1'b1, 5'd0, 6'd2, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h expected %h", k, obs, exp_v);
      end
      if (k == 4) bus.idx_ready = 1'b1;
      @(negedge clk);
    end
    exp_v = {1'b1, 1'b1, 5'd31, 6'd1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL stall_idx31: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 5'd0, 6'd0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL stall_done: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [13:0] exp_v;
    bus.load = 1'b1;
    bus.req = '0;
    bus.idx_ready = 1'b0;
    @(negedge clk);
    bus.load = 1'b0;
    exp_v = {1'b0, 1'b0, 5'd0, 6'd0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL zero_done: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = '0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL zero_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_all_ones();
    logic [13:0] exp_v;
    bus.load = 1'b1;
    bus.req = 32'hFFFF_FFFF;
    bus.idx_ready = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int k = 0; k < 32; k++) begin
      exp_v = {1'b1, 1'b1, 5'(k), 6'(32 - k), 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ones_idx%0d: got %h expected %h", k, obs, exp_v);
      end
      // A load during SCAN must not disturb the pending vector.
      if (k == 10) begin
        bus.load = 1'b1;
        bus.req = 32'h0000_0001;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    bus.req = '0;
    exp_v = {1'b0, 1'b0, 5'd0, 6'd0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL ones_done: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    logic [13:0] exp_v;
    bus.load = 1'b1;
    bus.req = 32'h0000_00F0;
    bus.idx_ready = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    exp_v = {1'b1, 1'b1, 5'd4, 6'd4, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rstmid_idx4: got %h expected %h", obs, exp_v);
    end
    @(posedge clk);
    #1;
    exp_v = {1'b1, 1'b1, 5'd5, 6'd3, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rstmid_idx5: got %h expected %h", obs, exp_v);
    end
    #1;
    rst = 1'b0;
    bus.idx_ready = 1'b0;
    #1;
    exp_v = '0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rstmid_async: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rstmid_nodone: got %h expected %h", obs, exp_v);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rstmid_release: got %h expected %h", obs, exp_v);
    end
    bus.load = 1'b1;
    bus.req = 32'h0000_0002;
    bus.idx_ready = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    exp_v = {1'b1, 1'b1, 5'd1, 6'd1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rstmid_idx1: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 5'd0, 6'd0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rstmid_done: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp_v;
    bus.load = 1'b1;
    bus.req = 32'h0000_0004;
    bus.idx_ready = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    exp_v = {1'b1, 1'b1, 5'd2, 6'd1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL b2b_idx2: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 5'd0, 6'd0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL b2b_done1: got %h expected %h", obs, exp_v);
    end
    bus.load = 1'b1;
    bus.req = 32'h0000_0010;
    @(negedge clk);
    bus.load = 1'b0;
    exp_v = {1'b1, 1'b1, 5'd4, 6'd1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL b2b_idx4: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {1'b0, 1'b0, 5'd0, 6'd0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL b2b_done2: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = '0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL b2b_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_all_ones();
    test_reset_mid_scan();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
